boa_stage_mem: RTL and testbench

- Boa³² pipeline stage MEM: memory access stage between EX and WB.
- Consumes the EX/MEM barrier: PC, instruction, address/ALU result, store data, trap.
- Runs the data-bus handshake for LOAD/STORE, aligns and sign-extends load data, and detects misaligned accesses.
- Requests a pipeline stall while a bus transfer is outstanding; forwards results to earlier stages and registers them into MEM/WB.

---
 rtl/boa_stage_mem.sv | 188 ++++++++++++++++++
 tb/tb_boa_stage_mem.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/boa_stage_mem.sv
// Boa32 MEM stage: data-bus handshake, load alignment/extension, misalignment traps,
// and the MEM/WB pipeline register.
module boa_stage_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        d_valid,
    input  logic [30:0] d_pc,
    input  logic [31:0] d_insn,
    input  logic        d_use_rd,
    input  logic [31:0] d_rs1_val,
    input  logic [31:0] d_rs2_val,
    input  logic        d_trap,
    input  logic [3:0]  d_cause,
    output logic        q_valid,
    output logic [30:0] q_pc,
    output logic [31:0] q_insn,
    output logic        q_use_rd,
    output logic [31:0] q_rd_val,
    output logic        q_trap,
    output logic [3:0]  q_cause,
    output logic        mem_re,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        fw_stall_mem,
    output logic        fw_stall_req,
    input  logic        fw_rs2,
    input  logic [31:0] fw_in,
    output logic        fw_rd,
    output logic [31:0] fw_out
);
    typedef enum logic [1:0] {StIdle, StBusy, StHeld} state_e;

    state_e      r_state, w_state_next;
    logic        r_discard, w_discard_next;
    logic [31:0] r_hold;
    logic        r_req_re;
    logic [3:0]  r_req_we;
    logic [29:0] r_req_addr;
    logic [31:0] r_req_wdata;

    logic        w_is_load, w_is_store, w_access, w_mis, w_go, w_stall, w_trap;
    logic [1:0]  w_size;
    logic [31:0] w_eff_wdata, w_lane_wdata, w_rsrc, w_lane, w_load_val, w_rd_val;
    logic [3:0]  w_be, w_cause;

    assign w_is_load   = d_insn[6:0] == 7'b0000011;
    assign w_is_store  = d_insn[6:0] == 7'b0100011;
    assign w_access    = d_valid && !d_trap && (w_is_load || w_is_store);
    assign w_size      = d_insn[13:12];
    assign w_mis       = (w_size == 2'b01 && d_rs1_val[0]) ||
                         (w_size[1] && d_rs1_val[1:0] != 2'b00);
    assign w_go        = w_access && !w_mis;
    assign w_eff_wdata = fw_rs2 ? fw_in : d_rs2_val;

    always_comb begin
        w_be         = 4'b1111;
        w_lane_wdata = w_eff_wdata;
        case (w_size)
            2'b00: begin
                w_be         = 4'b0001 << d_rs1_val[1:0];
                w_lane_wdata = {4{w_eff_wdata[7:0]}};
            end
            2'b01: begin
                w_be         = 4'b0011 << d_rs1_val[1:0];
                w_lane_wdata = {2{w_eff_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load data comes from the hold register once the bus has moved on.
    assign w_rsrc = (r_state == StHeld) ? r_hold : mem_rdata;
    assign w_lane = w_rsrc >> {d_rs1_val[1:0], 3'b000};

    always_comb begin
        w_load_val = w_lane;
        case (w_size)
            2'b00:   w_load_val = d_insn[14] ? {24'b0, w_lane[7:0]}
                                             : {{24{w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load_val = d_insn[14] ? {16'b0, w_lane[15:0]}
                                             : {{16{w_lane[15]}}, w_lane[15:0]};
            default: ;
        endcase
    end

    assign w_rd_val = w_is_load ? w_load_val : d_rs1_val;
    assign w_trap   = d_trap || (w_access && w_mis);
    assign w_cause  = d_trap ? d_cause : (w_is_load ? 4'd4 : 4'd6);

    // A discarded transfer keeps the stage stalled through its ready cycle.
    assign fw_stall_req = (r_state == StIdle && w_go && !mem_ready) ||
                          (r_state == StBusy && (!mem_ready || r_discard));
    assign w_stall      = fw_stall_mem || fw_stall_req;
    assign fw_rd        = d_valid && d_use_rd && !d_trap && !w_is_store && !fw_stall_req;
    assign fw_out       = w_rd_val;

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = d_rs1_val[31:2];
        mem_wdata = w_lane_wdata;
        if (r_state == StBusy) begin
            mem_addr  = r_req_addr;
            mem_wdata = r_req_wdata;
        end
        if (!rst) begin
            if (r_state == StIdle && w_go) begin
                mem_re = w_is_load;
                mem_we = w_is_store ? w_be : 4'b0000;
            end else if (r_state == StBusy) begin
                mem_re = r_req_re;
                mem_we = r_req_we;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_discard_next = r_discard;
        unique case (r_state)
            StIdle: begin
                w_discard_next = 1'b0;
                if (w_go && !mem_ready) begin
                    w_state_next   = StBusy;
                    w_discard_next = clear;
                end else if (w_go && fw_stall_mem) begin
                    w_state_next = StHeld;
                end
            end
            StBusy: begin
                w_discard_next = r_discard || clear;
                if (mem_ready) begin
                    w_discard_next = 1'b0;
                    if (!r_discard && !clear && fw_stall_mem) w_state_next = StHeld;
                    else                                      w_state_next = StIdle;
                end
            end
            StHeld: begin
                w_discard_next = 1'b0;
                if (clear || !fw_stall_mem) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_discard <= 1'b0;
            q_valid   <= 1'b0;
            q_trap    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
            if (!w_stall) begin
                q_valid <= d_valid;
                q_trap  <= w_trap;
            end else begin
                q_valid <= 1'b0;
            end
            if (clear) begin
                q_valid <= 1'b0;
                q_trap  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state != StHeld) r_hold <= mem_rdata;
        if (r_state == StIdle) begin
            r_req_re    <= w_is_load;
            r_req_we    <= w_is_store ? w_be : 4'b0000;
            r_req_addr  <= d_rs1_val[31:2];
            r_req_wdata <= w_lane_wdata;
        end
        if (!w_stall) begin
            q_pc     <= d_pc;
            q_insn   <= d_insn;
            q_use_rd <= d_use_rd;
            q_rd_val <= w_rd_val;
            q_cause  <= w_cause;
        end
    end
endmodule

// File: tb/tb_boa_stage_mem.sv
// Directed bench for boa_stage_mem: load/store lanes, misalignment, wait states,
// HELD hold-register path, clear and reset during an outstanding transfer.
module tb_boa_stage_mem;
    logic        clk = 1'b0;
    logic        rst, clear, d_valid, d_use_rd, d_trap;
    logic [30:0] d_pc;
    logic [31:0] d_insn, d_rs1_val, d_rs2_val;
    logic [3:0]  d_cause;
    logic        q_valid, q_use_rd, q_trap;
    logic [30:0] q_pc;
    logic [31:0] q_insn, q_rd_val;
    logic [3:0]  q_cause;
    logic        mem_re, mem_ready, fw_stall_mem, fw_stall_req, fw_rs2, fw_rd;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, fw_in, fw_out;

    int checks = 0;
    int errors = 0;

    boa_stage_mem dut (
        .clk(clk), .rst(rst), .clear(clear),
        .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_use_rd(d_use_rd),
        .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val), .d_trap(d_trap), .d_cause(d_cause),
        .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_use_rd(q_use_rd),
        .q_rd_val(q_rd_val), .q_trap(q_trap), .q_cause(q_cause),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .fw_stall_mem(fw_stall_mem), .fw_stall_req(fw_stall_req),
        .fw_rs2(fw_rs2), .fw_in(fw_in), .fw_rd(fw_rd), .fw_out(fw_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'b0, f3, 5'd1, op};
    endfunction

    // Present an instruction on the EX/MEM barrier.
    task automatic put(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] s);
        d_valid   = 1'b1;
        d_insn    = insn;
        d_rs1_val = a;
        d_rs2_val = s;
        d_use_rd  = (insn[6:0] != 7'b0100011);
        d_pc      = 31'h80;
    endtask

    localparam logic [6:0] OpLd = 7'b0000011;
    localparam logic [6:0] OpSt = 7'b0100011;
    localparam logic [6:0] OpAlu = 7'b0110011;

    initial begin
        rst = 1'b1; clear = 1'b0; d_valid = 1'b0; d_use_rd = 1'b0; d_trap = 1'b0;
        d_pc = '0; d_insn = '0; d_rs1_val = '0; d_rs2_val = '0; d_cause = '0;
        mem_ready = 1'b0; mem_rdata = '0; fw_stall_mem = 1'b0; fw_rs2 = 1'b0; fw_in = '0;
        tick(); tick();
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q_trap", q_trap, 0);
        rst = 1'b0;

        // LW, zero wait states
        put(mk(3'b010, OpLd), 32'h100, 0); mem_ready = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("lw_re", mem_re, 1);
        chk("lw_addr", mem_addr, 32'h40);
        chk("lw_stall", fw_stall_req, 0);
        chk("lw_fw_rd", fw_rd, 1);
        tick();
        chk("lw_rd_val", q_rd_val, 32'hDEADBEEF);
        chk("lw_q_valid", q_valid, 1);

        put(mk(3'b000, OpLd), 32'h103, 0); mem_rdata = 32'h80FF_0000; tick();
        chk("lb_val", q_rd_val, 32'hFFFFFF80);
        put(mk(3'b100, OpLd), 32'h103, 0); tick();
        chk("lbu_val", q_rd_val, 32'h00000080);
        put(mk(3'b101, OpLd), 32'h102, 0); tick();
        chk("lhu_val", q_rd_val, 32'h000080FF);

        // Stores
        put(mk(3'b000, OpSt), 32'h201, 32'h12345678); fw_rs2 = 1; fw_in = 32'hAA; #1;
        chk("sb_we", mem_we, 4'b0010);
        chk("sb_wdata", mem_wdata, 32'hAAAAAAAA);
        chk("sb_re", mem_re, 0);
        chk("sb_fw_rd", fw_rd, 0);
        tick();
        fw_rs2 = 0;
        put(mk(3'b001, OpSt), 32'h202, 32'h12345678); #1;
        chk("sh_we", mem_we, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'h56785678);
        tick();

        // Misaligned
        put(mk(3'b010, OpLd), 32'h102, 0); #1;
        chk("mis_lw_re", mem_re, 0);
        chk("mis_lw_stall", fw_stall_req, 0);
        tick();
        chk("mis_lw_trap", q_trap, 1);
        chk("mis_lw_cause", q_cause, 4);
        put(mk(3'b001, OpSt), 32'h101, 32'h5555); #1;
        chk("mis_sh_we", mem_we, 0);
        tick();
        chk("mis_sh_trap", q_trap, 1);
        chk("mis_sh_cause", q_cause, 6);

        // ALU passthrough
        put(mk(3'b000, OpAlu), 32'h1234, 0); tick();
        chk("alu_val", q_rd_val, 32'h1234);
        chk("alu_valid", q_valid, 1);
        chk("alu_trap", q_trap, 0);

        // LW with 3 wait states
        put(mk(3'b010, OpLd), 32'h300, 0); mem_ready = 0; mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_stall", fw_stall_req, 1);
            chk("ws_re", mem_re, 1);
            chk("ws_addr", mem_addr, 32'hC0);
            tick();
            chk("ws_q_valid", q_valid, 0);
        end
        mem_ready = 1; mem_rdata = 32'hCAFEF00D; #1;
        chk("ws_ready_stall", fw_stall_req, 0);
        tick();
        chk("ws_valid", q_valid, 1);
        chk("ws_val", q_rd_val, 32'hCAFEF00D);

        // Ready while externally stalled -> HELD
        put(mk(3'b010, OpLd), 32'h304, 0); mem_ready = 0; tick();
        mem_ready = 1; mem_rdata = 32'h11223344; fw_stall_mem = 1; tick();
        chk("held_q_valid0", q_valid, 0);
        mem_ready = 0; mem_rdata = 32'h0; #1;
        chk("held_re", mem_re, 0);
        chk("held_stall_req", fw_stall_req, 0);
        tick();
        chk("held_q_valid1", q_valid, 0);
        fw_stall_mem = 0; #1;
        chk("held_re2", mem_re, 0);
        chk("held_fw_out", fw_out, 32'h11223344);
        tick();
        chk("held_val", q_rd_val, 32'h11223344);
        chk("held_valid", q_valid, 1);

        // clear during BUSY: transfer runs to completion, data discarded
        put(mk(3'b010, OpLd), 32'h400, 0); mem_ready = 0; tick();
        clear = 1; d_valid = 0; tick();
        chk("clr_q_valid0", q_valid, 0);
        clear = 0; #1;
        chk("clr_re", mem_re, 1);
        chk("clr_addr", mem_addr, 32'h100);
        chk("clr_stall", fw_stall_req, 1);
        tick();
        chk("clr_q_valid1", q_valid, 0);
        mem_ready = 1; mem_rdata = 32'h77777777; #1;
        chk("clr_re_ready", mem_re, 1);
        tick();
        chk("clr_q_valid2", q_valid, 0);
        mem_ready = 0; #1;
        chk("clr_idle_re", mem_re, 0);
        chk("clr_idle_stall", fw_stall_req, 0);

        // rst during BUSY
        put(mk(3'b010, OpLd), 32'h500, 0); mem_ready = 0; tick();
        chk("rstb_re_busy", mem_re, 1);
        rst = 1; #1;
        chk("rstb_re", mem_re, 0);
        tick();
        chk("rstb_q_valid", q_valid, 0);
        chk("rstb_q_trap", q_trap, 0);
        rst = 0; d_valid = 0; #1;
        chk("rstb_idle_re", mem_re, 0);
        chk("rstb_idle_stall", fw_stall_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
